// File: rtl/iq_pkg.sv
// Shared types for the front-end instruction queue.
package iq_pkg;
  localparam int INST_WIDTH = 32;
  typedef logic [INST_WIDTH-1:0] inst_t;
endpackage

// File: rtl/instr_queue_if.sv
// Fetch-push / dispatch-pop bundle of the instruction queue.
interface instr_queue_if
  import iq_pkg::*;
#(
  parameter int WIDTH = INST_WIDTH
);
  logic             valid_in;
  logic [WIDTH-1:0] instruction_in;
  logic             ready_out;
  logic             output_read_in;
  logic             inst_available_out;
  logic [WIDTH-1:0] instruction_out;

  modport master (
    output valid_in,
    output instruction_in,
    output output_read_in,
    input  ready_out,
    input  inst_available_out,
    input  instruction_out
  );

  modport slave (
    input  valid_in,
    input  instruction_in,
    input  output_read_in,
    output ready_out,
    output inst_available_out,
    output instruction_out
  );
endinterface

// File: rtl/iq_wrap_ptr.sv
// Ring pointer that wraps SIZE-1 -> 0 (any SIZE, not only 2^n).
// IQ_FLUSH_EN adds a synchronous clear input.
module iq_wrap_ptr #(
  parameter  int SIZE = 4,
  localparam int PW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clk,
  input  logic          reset,
`ifdef IQ_FLUSH_EN
  input  logic          clear,
`endif
  input  logic          advance,
  output logic [PW-1:0] pointer
);
  localparam logic [PW-1:0] LAST = PW'(SIZE - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
`ifdef IQ_FLUSH_EN
    if (clear) begin
      ptr_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign pointer = ptr_q;
endmodule

// File: rtl/instr_queue.sv
// Show-ahead instruction FIFO between fetch and dispatch.
// IQ_FLUSH_EN adds flush_in (sync, active-high) that empties the queue.
module instr_queue
  import iq_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WIDTH = INST_WIDTH
) (
  input logic            clk_in,
  input logic            rst_in,
`ifdef IQ_FLUSH_EN
  input logic            flush_in,
`endif
  instr_queue_if.slave   q_if
);
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(SIZE);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    head, tail;
  logic             avail, ready;
  logic             push, pop, flush;

`ifdef IQ_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  assign avail = (cnt_q != '0);
  assign ready = (cnt_q != FULL);
  assign push  = q_if.valid_in && ready;
  assign pop   = q_if.output_read_in && avail;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[tail] <= q_if.instruction_in;
    end
  end

  iq_wrap_ptr #(.SIZE(SIZE)) u_head (
    .clk     (clk_in),
    .reset   (rst_in),
`ifdef IQ_FLUSH_EN
    .clear   (flush),
`endif
    .advance (pop),
    .pointer (head)
  );

  iq_wrap_ptr #(.SIZE(SIZE)) u_tail (
    .clk     (clk_in),
    .reset   (rst_in),
`ifdef IQ_FLUSH_EN
    .clear   (flush),
`endif
    .advance (push),
    .pointer (tail)
  );

  assign q_if.inst_available_out = avail;
  assign q_if.ready_out          = ready;
  assign q_if.instruction_out    = avail ? mem_q[head] : '0;
endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: vector table, corner sequences,
// and randomized traffic against a queue-based reference.
module tb_instr_queue;
  import iq_pkg::*;

  localparam int SIZE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
`ifdef IQ_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_queue_if #(.WIDTH(INST_WIDTH)) q_if ();

  instr_queue #(.SIZE(SIZE), .WIDTH(INST_WIDTH)) dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
`ifdef IQ_FLUSH_EN
    .flush_in (flush),
`endif
    .q_if     (q_if)
  );

  int checks   = 0;
  int failures = 0;
  inst_t model[$];

  typedef struct {
    bit    push;
    inst_t din;
    bit    pop;
    bit    avail;
    bit    rdy;
    inst_t out;
  } vec_t;

  vec_t tbl[18];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    inst_t exp_out;
    exp_out = (model.size() != 0) ? model[0] : '0;
    check({tag, ".avail"}, 32'(q_if.inst_available_out),
          32'(model.size() != 0));
    check({tag, ".ready"}, 32'(q_if.ready_out), 32'(model.size() != SIZE));
    check({tag, ".out"}, q_if.instruction_out, exp_out);
  endtask

  // drive at negedge, sample 1ns after the rising edge
  task automatic step(bit push, inst_t d, bit pop);
    bit pf, of;
    @(negedge clk);
    q_if.valid_in       = push;
    q_if.instruction_in = d;
    q_if.output_read_in = pop;
    pf = push && (model.size() < SIZE);
    of = pop && (model.size() != 0);
    @(posedge clk);
    #1;
    if (of) void'(model.pop_front());
    if (pf) model.push_back(d);
  endtask

  task automatic set_vec(int i, bit pu, inst_t d, bit po,
                         bit a, bit r, inst_t o);
    tbl[i] = '{pu, d, po, a, r, o};
  endtask

  initial begin
    q_if.valid_in       = 1'b0;
    q_if.instruction_in = '0;
    q_if.output_read_in = 1'b0;

    set_vec(0,  0, 32'h00, 0, 0, 1, 32'h0);
    set_vec(1,  1, 32'h0E, 0, 1, 1, 32'hE);
    set_vec(2,  1, 32'h0F, 0, 1, 1, 32'hE);
    set_vec(3,  0, 32'h00, 1, 1, 1, 32'hF);
    set_vec(4,  0, 32'h00, 1, 0, 1, 32'h0);
    set_vec(5,  1, 32'h0A, 0, 1, 1, 32'hA);
    set_vec(6,  1, 32'h0B, 0, 1, 1, 32'hA);
    set_vec(7,  1, 32'h0C, 0, 1, 1, 32'hA);
    set_vec(8,  1, 32'h0D, 0, 1, 0, 32'hA);
    set_vec(9,  1, 32'h99, 0, 1, 0, 32'hA);
    set_vec(10, 0, 32'h00, 1, 1, 1, 32'hB);
    set_vec(11, 1, 32'h05, 1, 1, 1, 32'hC);
    set_vec(12, 0, 32'h00, 1, 1, 1, 32'hD);
    set_vec(13, 0, 32'h00, 1, 1, 1, 32'h5);
    set_vec(14, 0, 32'h00, 1, 0, 1, 32'h0);
    set_vec(15, 1, 32'h07, 1, 1, 1, 32'h7);
    set_vec(16, 0, 32'h00, 1, 0, 1, 32'h0);
    set_vec(17, 0, 32'h00, 1, 0, 1, 32'h0);

    #1 rst_n = 1'b0;
    #2;
    check("rst.avail", 32'(q_if.inst_available_out), 32'd0);
    check("rst.ready", 32'(q_if.ready_out), 32'd1);
    check("rst.out", q_if.instruction_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].push, tbl[i].din, tbl[i].pop);
      check($sformatf("vec%0d.avail", i), 32'(q_if.inst_available_out),
            32'(tbl[i].avail));
      check($sformatf("vec%0d.ready", i), 32'(q_if.ready_out),
            32'(tbl[i].rdy));
      check($sformatf("vec%0d.out", i), q_if.instruction_out, tbl[i].out);
    end

    // asynchronous reset with three entries queued
    step(1, 32'h1, 0);
    step(1, 32'h2, 0);
    step(1, 32'h3, 0);
    check_model("pre_rst");
    step(0, 32'h0, 0);
    #2 rst_n = 1'b0;
    model.delete();
    #1;
    check_model("async_rst");
    @(posedge clk);
    #1;
    check_model("rst_held");
    #1 rst_n = 1'b1;
    step(1, 32'h44, 0);
    check_model("post_rst_push");
    check("post_rst.val", q_if.instruction_out, 32'h44);
    step(0, 32'h0, 1);
    check_model("post_rst_pop");

`ifdef IQ_FLUSH_EN
    step(1, 32'h1, 0);
    step(1, 32'h2, 0);
    @(negedge clk);
    flush               = 1'b1;
    q_if.valid_in       = 1'b1;
    q_if.instruction_in = 32'h3;
    q_if.output_read_in = 1'b1;
    @(posedge clk);
    #1;
    model.delete();
    check_model("flush");
    @(negedge clk);
    flush = 1'b0;
    step(1, 32'h8, 0);
    check_model("after_flush");
    step(0, 32'h0, 1);
`endif

    // randomized traffic, with push/pop bias varied to reach full and empty
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 150; n++) begin
        int pp, qp;
        pp = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
        qp = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
        step($urandom_range(0, 99) < pp, inst_t'($urandom),
             $urandom_range(0, 99) < qp);
        check_model($sformatf("rnd%0d_%0d", ph, n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
